// File: rtl/maze_cmd_pkg.sv
// Shared types and constants for the maze command scheduler: FSM states,
// error codes, the acknowledge byte and command opcodes.
package maze_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_SENT = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_ERR       = 3'd4
    } sched_state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_NAK  = 2'b01,
        ERR_TMO  = 2'b10
    } err_code_e;

    localparam logic [7:0] ACK_BYTE = 8'hA5;

    localparam logic [2:0] OP_CAL   = 3'b000;
    localparam logic [2:0] OP_HDG   = 3'b001;
    localparam logic [2:0] OP_MOVE  = 3'b010;
    localparam logic [2:0] OP_SOLVE = 3'b011;

    // Solve commands can legitimately take unbounded time on the remote side.
    function automatic logic is_solve(input logic [15:0] c);
        return c[15:13] == OP_SOLVE;
    endfunction

endpackage

// File: rtl/cmd_scheduler_if.sv
// Link between the scheduler and the RemoteComm transmitter/receiver.
interface cmd_scheduler_if;

    logic        send_cmd;
    logic [15:0] cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    modport master (
        output send_cmd,
        output cmd,
        input  cmd_sent,
        input  resp_rdy,
        input  resp
    );

    modport slave (
        input  send_cmd,
        input  cmd,
        output cmd_sent,
        output resp_rdy,
        output resp
    );

endinterface

// File: rtl/cmd_scheduler_fifo.sv
// Circular command queue. A push into a full queue is dropped even if a pop
// happens in the same cycle; flush wins over both push and pop.
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;

    // Pointers are AW bits wide, so wrap-around is free for power-of-2 DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cmd_scheduler.sv
// Command scheduler: drains the command queue one command at a time through
// RemoteComm, waits for the ack byte, and stops on NAK or response timeout.
//
// state        | meaning
// ST_IDLE      | waiting for a queued command (blocked while err is set)
// ST_SEND      | one-cycle send_cmd strobe, cmd stable
// ST_WAIT_SENT | waiting for RemoteComm transmit done
// ST_WAIT_RESP | waiting for response byte
// ST_ERR       | stalled on NAK or timeout until clr_err
module cmd_scheduler
    import maze_cmd_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TMO_CYC = 2**22
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [15:0]             push_cmd,
    input  logic                    abort,
    input  logic                    clr_err,
    cmd_scheduler_if.master         rc,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [1:0]              err_code,
    output logic                    ovf
);

    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    sched_state_e state;
    sched_state_e state_nxt;
    logic [15:0]  cmd_q;
    logic [TW-1:0] tmo_cnt;
    err_code_e    err_code_q;
    logic         err_q;
    logic         ovf_q;

    logic [15:0]  head_data;
    logic         fifo_empty;
    logic         fifo_full;
    logic         pop_c;
    logic         send_c;
    logic         done_c;
    logic         set_nak_c;
    logic         set_tmo_c;
    logic         tmo_clr_c;
    logic         tmo_inc_c;
    logic         tmo_hit;
    logic         tmo_exempt;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop_c),
        .flush     (abort),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign tmo_exempt = is_solve(cmd_q);
    assign tmo_hit    = !tmo_exempt && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        pop_c     = 1'b0;
        send_c    = 1'b0;
        done_c    = 1'b0;
        set_nak_c = 1'b0;
        set_tmo_c = 1'b0;
        tmo_clr_c = 1'b0;
        tmo_inc_c = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !err_q) begin
                    pop_c     = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                send_c    = 1'b1;
                tmo_clr_c = 1'b1;
                state_nxt = ST_WAIT_SENT;
            end
            ST_WAIT_SENT: begin
                if (rc.cmd_sent) begin
                    tmo_clr_c = 1'b1;
                    state_nxt = ST_WAIT_RESP;
                end else if (tmo_hit) begin
                    set_tmo_c = 1'b1;
                    state_nxt = ST_ERR;
                end else begin
                    tmo_inc_c = !tmo_exempt;
                end
            end
            ST_WAIT_RESP: begin
                // A response arriving on the timeout cycle still counts.
                if (rc.resp_rdy) begin
                    if (rc.resp == ACK_BYTE) begin
                        done_c    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        set_nak_c = 1'b1;
                        state_nxt = ST_ERR;
                    end
                end else if (tmo_hit) begin
                    set_tmo_c = 1'b1;
                    state_nxt = ST_ERR;
                end else begin
                    tmo_inc_c = !tmo_exempt;
                end
            end
            ST_ERR: begin
                if (clr_err) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (abort) begin
            state_nxt = ST_IDLE;
            pop_c     = 1'b0;
            send_c    = 1'b0;
            done_c    = 1'b0;
            set_nak_c = 1'b0;
            set_tmo_c = 1'b0;
            tmo_inc_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cmd_q      <= 16'h0000;
            tmo_cnt    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            ovf_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pop_c) cmd_q <= head_data;

            if (tmo_clr_c)      tmo_cnt <= '0;
            else if (tmo_inc_c) tmo_cnt <= tmo_cnt + 1'b1;

            if (set_nak_c) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_NAK;
            end else if (set_tmo_c) begin
                err_q      <= 1'b1;
                err_code_q <= ERR_TMO;
            end else if (clr_err) begin
                err_q      <= 1'b0;
                err_code_q <= ERR_NONE;
            end

            // An aborted push never reaches the queue, so it cannot overflow it.
            if (push && fifo_full && !abort) ovf_q <= 1'b1;
        end
    end

    // Strobes are blocked during reset so an abandoned command emits nothing.
    assign rc.send_cmd = send_c && !rst;
    assign rc.cmd      = cmd_q;
    assign done        = done_c && !rst;
    assign busy        = (state == ST_SEND) || (state == ST_WAIT_SENT) ||
                         (state == ST_WAIT_RESP);
    assign full        = fifo_full;
    assign empty       = fifo_empty;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Scoreboard bench for cmd_scheduler: accepted pushes form the expected issue
// order, a remote-side process answers strobes, a monitor checks every strobe.
module tb_cmd_scheduler;
    import maze_cmd_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 100;

    localparam int RM_ACK   = 0;
    localparam int RM_NAK   = 1;
    localparam int RM_NONE  = 2;
    localparam int RM_NOEXP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic [15:0] push_cmd = 16'h0;
    logic        abort = 1'b0;
    logic        clr_err = 1'b0;
    logic        full, empty, busy, done, err, ovf;
    logic [3:0]  count;
    logic [1:0]  err_code;

    cmd_scheduler_if rc();

    cmd_scheduler #(
        .DEPTH   (DEPTH),
        .TMO_CYC (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_cmd (push_cmd),
        .abort    (abort),
        .clr_err  (clr_err),
        .rc       (rc),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] mq[$];
    int          exp_done = 0;
    int          n_send = 0;
    int          n_done = 0;
    logic        exp_ovf = 1'b0;
    logic        prev_send = 1'b0;
    int          rmt_mode = RM_ACK;
    int          rmt_sent_dly = 0;
    int          rmt_resp_dly = 0;
    int          rmt_sent_cyc = 0;
    logic [7:0]  rmt_nak = 8'h5A;
    logic        rmt_in_resp = 1'b0;
    int          err_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every strobe must match the oldest accepted command.
    initial forever begin
        logic [15:0] e;
        @(negedge clk);
        if (rc.send_cmd) begin
            check("send_single", prev_send, 1'b0);
            check("send_pending", (mq.size() > 0), 1'b1);
            n_send++;
            if (mq.size() > 0) begin
                e = mq.pop_front();
                check("issue_cmd", rc.cmd, e);
            end
        end
        prev_send = rc.send_cmd;
        if (done) begin
            check("done_pending", (exp_done > 0), 1'b1);
            if (exp_done > 0) exp_done--;
            n_done++;
        end
    end

    // Remote side: transmit-done then (optionally) one response byte.
    initial begin
        rc.cmd_sent = 1'b0;
        rc.resp_rdy = 1'b0;
        rc.resp     = 8'h00;
        forever begin
            @(negedge clk);
            if (rc.send_cmd) begin
                @(posedge clk); #1;
                repeat (rmt_sent_dly) begin @(posedge clk); #1; end
                rc.cmd_sent  = 1'b1;
                rmt_sent_cyc = cyc + 1;
                @(posedge clk); #1;
                rc.cmd_sent = 1'b0;
                rmt_in_resp = 1'b1;
                if (rmt_mode != RM_NONE) begin
                    repeat (rmt_resp_dly) begin @(posedge clk); #1; end
                    rc.resp = (rmt_mode == RM_NAK) ? rmt_nak : ACK_BYTE;
                    if (rmt_mode == RM_ACK) exp_done++;
                    rc.resp_rdy = 1'b1;
                    @(posedge clk); #1;
                    rc.resp_rdy = 1'b0;
                    rc.resp     = 8'($urandom);
                end
                rmt_in_resp = 1'b0;
            end
        end
    end

    // All main-thread tasks start and end just after a rising edge.
    task automatic push_one(input logic [15:0] c);
        push     = 1'b1;
        push_cmd = c;
        if (mq.size() < DEPTH) mq.push_back(c);
        else                   exp_ovf = 1'b1;
        @(posedge clk); #1;
        push = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && empty) begin ok = 1'b1; break; end
        end
        check(name, ok, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic wait_err(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (err) begin ok = 1'b1; err_cyc = cyc; break; end
        end
        check(name, ok, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, n;
        logic [15:0] c;
        logic [7:0]  b;
        bit          seen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_code", err_code, 2'b00);
        check("rst_ovf", ovf, 1'b0);
        check("rst_send", rc.send_cmd, 1'b0);
        check("rst_cmd", rc.cmd, 16'h0000);
        @(posedge clk); #1;

        // Single command, acked.
        rmt_mode = RM_ACK; rmt_sent_dly = 2; rmt_resp_dly = 3;
        s0 = n_send; d0 = n_done;
        push_one(16'h0000);
        wait_idle("single_idle", 200);
        check("single_sends", n_send - s0, 1);
        check("single_dones", n_done - d0, 1);
        check("single_busy", busy, 1'b0);
        check("single_all_acked", exp_done, 0);

        // Three back-to-back commands.
        s0 = n_send; d0 = n_done;
        push_one(16'h4000);
        push_one(16'h23FF);
        push_one(16'h4002);
        wait_idle("three_idle", 300);
        check("three_sends", n_send - s0, 3);
        check("three_dones", n_done - d0, 3);
        check("three_empty", empty, 1'b1);
        check("three_cmd_hold", rc.cmd, 16'h4002);

        // Randomized bursts with random remote latency.
        for (int it = 0; it < 25; it++) begin
            rmt_sent_dly = $urandom_range(0, 12);
            rmt_resp_dly = $urandom_range(0, 12);
            n = $urandom_range(1, 4);
            s0 = n_send; d0 = n_done;
            c = 16'h0;
            for (int k = 0; k < n; k++) begin
                c = {3'($urandom_range(0, 3)), 13'($urandom)};
                push_one(c);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            wait_idle("rand_idle", 500);
            check("rand_sends", n_send - s0, n);
            check("rand_dones", n_done - d0, n);
            check("rand_cmd_hold", rc.cmd, c);
        end
        check("rand_all_acked", exp_done, 0);

        // NAK stalls with the queue retained; clr_err resumes.
        rmt_mode = RM_NAK; rmt_nak = 8'h5A; rmt_sent_dly = 1; rmt_resp_dly = 2;
        push_one(16'h4000);
        push_one(16'h2001);
        wait_err("nak_err", 200);
        check("nak_code", err_code, 2'b01);
        check("nak_count", count, mq.size());
        check("nak_retained", empty, (mq.size() == 0));
        check("nak_busy", busy, 1'b0);
        rmt_mode = RM_ACK;
        pulse_clr();
        @(negedge clk);
        check("clr_err", err, 1'b0);
        check("clr_code", err_code, 2'b00);
        @(posedge clk); #1;
        wait_idle("nak_resume_idle", 200);
        check("nak_resume_cmd", rc.cmd, 16'h2001);
        check("nak_resume_acked", exp_done, 0);

        // Response timeout, measured from the cmd_sent edge.
        rmt_mode = RM_NONE; rmt_sent_dly = 0;
        push_one(16'h4000);
        wait_err("tmo_err", 400);
        check("tmo_cycles", err_cyc - rmt_sent_cyc, TMO);
        check("tmo_code", err_code, 2'b10);
        pulse_clr();
        @(negedge clk);
        check("tmo_clr", err, 1'b0);
        @(posedge clk); #1;

        // Solve command is never timed out; abort retires it.
        push_one(16'h6000);
        repeat (1020) @(posedge clk);
        #1;
        @(negedge clk);
        check("solve_no_err", err, 1'b0);
        check("solve_busy", busy, 1'b1);
        @(posedge clk); #1;
        abort = 1'b1;
        mq.delete();
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("solve_abort_busy", busy, 1'b0);
        check("solve_abort_err", err, 1'b0);
        @(posedge clk); #1;

        // Overflow while stalled in ERR, then abort with a colliding push.
        rmt_mode = RM_NAK;
        b = 8'($urandom);
        if (b == ACK_BYTE) b = 8'h00;
        rmt_nak = b;
        push_one(16'h4000);
        wait_err("ovf_stall", 200);
        for (int i = 0; i < DEPTH + 1; i++) push_one(16'h2000 + 16'(i));
        @(negedge clk);
        check("ovf_full", full, (mq.size() == DEPTH));
        check("ovf_count", count, mq.size());
        check("ovf_flag", ovf, exp_ovf);
        @(posedge clk); #1;
        s0 = n_send;
        abort = 1'b1; push = 1'b1; push_cmd = 16'hBEEF;
        mq.delete();
        @(posedge clk); #1;
        abort = 1'b0; push = 1'b0;
        @(negedge clk);
        check("abort_count", count, mq.size());
        check("abort_empty", empty, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_err_kept", err, 1'b1);
        check("abort_ovf_kept", ovf, exp_ovf);
        @(posedge clk); #1;
        pulse_clr();
        @(negedge clk);
        check("ovf_clr_err", err, 1'b0);
        check("ovf_survives_clr", ovf, exp_ovf);
        repeat (10) @(negedge clk);
        check("abort_no_issue", n_send - s0, 0);
        @(posedge clk); #1;

        // Reset while waiting for the response.
        rmt_mode = RM_NOEXP; rmt_sent_dly = 1; rmt_resp_dly = 10;
        push_one(16'h4001);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rmt_in_resp) begin seen = 1'b1; break; end
        end
        check("rstm_reached_resp", seen, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        exp_ovf = 1'b0;
        d0 = n_done;
        @(negedge clk);
        check("rstm_busy", busy, 1'b0);
        check("rstm_cmd", rc.cmd, 16'h0000);
        check("rstm_ovf", ovf, exp_ovf);
        check("rstm_empty", empty, 1'b1);
        check("rstm_count", count, 0);
        check("rstm_err", err, 1'b0);
        check("rstm_code", err_code, 2'b00);
        check("rstm_send", rc.send_cmd, 1'b0);
        check("rstm_done", done, 1'b0);
        repeat (20) @(negedge clk);
        check("rstm_late_resp_no_done", n_done - d0, 0);
        check("rstm_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_scheduler.md
CMD_SCHEDULER -- requirements
Module: cmd_scheduler

Interface
REQ-001 SHALL have parameters: DEPTH, default 8, command queue entries (power of 2); TMO_CYC, default 2**22, response timeout in clk cycles.
REQ-002 SHALL have ports: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: push  in  1  enqueue request; push_cmd  in  16  command to enqueue; abort  in  1  flush queue and return to IDLE; clr_err  in  1  clear error and resume.
REQ-004 SHALL have ports: send_cmd  out  1  one-cycle strobe to RemoteComm; cmd  out  16  command to RemoteComm; cmd_sent  in  1  RemoteComm transmit done; resp_rdy  in  1  response byte valid; resp  in  8  response byte.
REQ-005 SHALL have ports: full  out  1; empty  out  1; count  out  $clog2(DEPTH)+1  entries queued; busy  out  1  command in flight; done  out  1  one-cycle pulse on good ack; err  out  1  sticky error; err_code  out  2  00 none, 01 NAK, 10 timeout; ovf  out  1  sticky push-while-full.
REQ-006 SHALL use one clock (clk) and a synchronous, active-high reset (rst), fixed by decision.

Function
REQ-007 SHALL hold a circular FIFO of DEPTH 16-bit commands; push when not full writes push_cmd at tail.
REQ-008 SHALL drop push when full (including a pop in the same cycle) and set ovf.
REQ-009 SHALL keep count unchanged on simultaneous accepted push and pop; pointers wrap modulo DEPTH.
REQ-010 SHALL implement states IDLE, SEND, WAIT_SENT, WAIT_RESP, ERR.
REQ-011 IDLE: when !empty and !err, SHALL pop head into cmd register and go to SEND next cycle.
REQ-012 SEND: SHALL assert send_cmd for exactly one cycle with cmd stable, then go to WAIT_SENT.
REQ-013 WAIT_SENT: SHALL wait for cmd_sent, then go to WAIT_RESP and clear the timeout counter.
REQ-014 WAIT_RESP: on resp_rdy with resp==8'hA5, SHALL pulse done for one cycle and return to IDLE.
REQ-015 WAIT_RESP: on resp_rdy with resp!=8'hA5, SHALL set err, set err_code=01, and go to ERR.
REQ-016 SHALL count cycles in WAIT_SENT and WAIT_RESP; on reaching TMO_CYC-1, SHALL set err_code=10 and go to ERR.
REQ-017 SHALL exempt commands with cmd[15:13]==3'b011 (solve) from timeout; they wait indefinitely for resp_rdy.
REQ-018 ERR: SHALL retain queue contents; clr_err SHALL clear err and err_code (not ovf) and return to IDLE.
REQ-019 abort in any state SHALL empty the queue, go to IDLE next cycle, and suppress send_cmd and done that cycle; err and ovf SHALL be unaffected.
REQ-020 SHALL give abort priority over push in the same cycle, so the pushed command is discarded.
REQ-021 SHALL assert busy in SEND, WAIT_SENT and WAIT_RESP only.
REQ-022 SHALL hold cmd at its last issued value until the next pop.
REQ-023 SHALL ignore resp_rdy outside WAIT_RESP.

Reset
REQ-024 On rst, SHALL set state=IDLE, pointers=0, count=0, empty=1, full=0, send_cmd=0, cmd=16'h0000, busy=0, done=0, err=0, err_code=00, ovf=0, and timeout counter=0.
REQ-025 rst asserted mid-command SHALL abandon the command without a send_cmd or done pulse.

Structure
REQ-026 SHALL place state enum, err_code encodings, ACK_BYTE=8'hA5 and opcode constants (CAL=3'b000, HDG=3'b001, MOVE=3'b010, SOLVE=3'b011) in shared package maze_cmd_pkg.
REQ-027 SHALL implement the queue as sub-module cmd_fifo (parameterized DEPTH, width 16); FSM and timeout stay in cmd_scheduler.

Verification
REQ-028 Push 0x0000 while idle -> send_cmd pulses for one cycle with cmd=0x0000; after cmd_sent and resp_rdy with resp=0xA5, done pulses once and busy=0.
REQ-029 Push 0x4000, 0x23FF, 0x4002 back-to-back and ack each with 0xA5 -> issued in order, exactly three send_cmd strobes and three done pulses, empty=1 at end.
REQ-030 Push 0x4000 and answer with resp=0x5A -> err=1, err_code=01, queue retained; clr_err -> next queued command issued.
REQ-031 With TMO_CYC=100, push 0x4000 and give no resp_rdy -> err_code=10 at cycle 100 after cmd_sent; push 0x6000 with no resp for 1000 cycles -> no error.
REQ-032 Push DEPTH+1 commands while stalled in ERR -> full=1, count=DEPTH, ovf=1; abort -> count=0, empty=1, state IDLE.
REQ-033 Assert rst while in WAIT_RESP -> all outputs at reset values on the next cycle; a later resp_rdy produces no done pulse.
